// File: rtl/seq_ones_counter_pkg.sv
// seq_ones_counter_pkg
//   Shared definitions for the sequential population counter:
//   - state_t     : FSM state encoding (IDLE / RUN / DONE)
//   - ceil_div    : integer ceiling division, used for the number of chunks
//   - clog2_int   : ceiling log2, used for result and chunk-count widths
package seq_ones_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Smallest r with 2**r >= v; clog2_int(1) = 0.
  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_ones_counter_if.sv
// seq_ones_counter_if
//   Request/result bundle of the sequential population counter.
//   start, mode, din     : request side (driven by the master)
//   ready, busy, done,
//   count                : status/result side (driven by the counter)
//   WIDTH sets the data word width; the count width follows from it.
interface seq_ones_counter_if
  import seq_ones_counter_pkg::*;
#(
  parameter int WIDTH = 63
);
  localparam int RW = clog2_int(WIDTH + 1);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             busy;
  logic             done;
  logic [RW-1:0]    count;

  modport master (output start, mode, din, input ready, busy, done, count);
  modport slave  (input start, mode, din, output ready, busy, done, count);
endinterface

// File: rtl/seq_ones_counter_chunk_popcount.sv
// chunk_popcount
//   Pure combinational ones counter for a CHUNK-bit slice.
//   word : CHUNK-bit input slice
//   ones : number of set bits in word, clog2(CHUNK+1) bits wide
module chunk_popcount
  import seq_ones_counter_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]                word,
  output logic [clog2_int(CHUNK+1)-1:0]   ones
);
  localparam int CW = clog2_int(CHUNK + 1);

  always_comb begin
    ones = '0;
    for (int i = 0; i < CHUNK; i++) begin
      ones = ones + CW'(word[i]);
    end
  end
endmodule

// File: rtl/seq_ones_counter.sv
// seq_ones_counter
//   Multi-cycle population counter. An accepted start latches din (inverted
//   when mode=1 so that zeros are counted), then CHUNK bits are counted per
//   clock until the whole word is consumed; done pulses for one cycle and
//   count holds the result until the next completion.
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of seq_ones_counter_if (start/mode/din in,
//          ready/busy/done/count out)
module seq_ones_counter
  import seq_ones_counter_pkg::*;
#(
  parameter int WIDTH = 63,
  parameter int CHUNK = 8
) (
  input logic               clk,
  input logic               rst,
  seq_ones_counter_if.slave bus
);
  localparam int NCHUNK = ceil_div(WIDTH, CHUNK);
  localparam int RW     = clog2_int(WIDTH + 1);
  localparam int PW     = NCHUNK * CHUNK;
  localparam int CW     = clog2_int(CHUNK + 1);
  localparam int IW     = (NCHUNK > 1) ? clog2_int(NCHUNK) : 1;

  state_t          state_reg, state_next;
  logic [PW-1:0]   shift_reg, shift_next;
  logic [RW-1:0]   acc_reg, acc_next;
  logic [IW-1:0]   idx_reg, idx_next;
  logic [RW-1:0]   count_reg, count_next;

  logic [WIDTH-1:0] word;
  logic [PW-1:0]    padded;
  logic [CW-1:0]    chunk_ones;

  // Inversion happens before padding so pad bits are always zero and never
  // contribute, whichever mode is selected.
  assign word = bus.mode ? ~bus.din : bus.din;

  generate
    for (genvar gi = 0; gi < PW; gi++) begin : g_pad
      if (gi < WIDTH) begin : g_data
        assign padded[gi] = word[gi];
      end else begin : g_zero
        assign padded[gi] = 1'b0;
      end
    end
  endgenerate

  chunk_popcount #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .word(shift_reg[CHUNK-1:0]),
    .ones(chunk_ones)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    acc_next   = acc_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          shift_next = padded;
          acc_next   = '0;
          idx_next   = '0;
        end
      end
      RUN: begin
        // The chunk count never exceeds WIDTH, so the cast cannot lose value.
        acc_next   = acc_reg + RW'(chunk_ones);
        shift_next = shift_reg >> CHUNK;
        idx_next   = idx_reg + 1'b1;
        if (idx_reg == IW'(NCHUNK - 1)) begin
          state_next = DONE;
          count_next = acc_next;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      acc_reg   <= '0;
      idx_reg   <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      acc_reg   <= acc_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
    end
  end

  assign bus.ready = (state_reg == IDLE);
  assign bus.busy  = (state_reg == RUN);
  assign bus.done  = (state_reg == DONE);
  assign bus.count = count_reg;
endmodule

// File: tb/tb_seq_ones_counter.sv
// tb_seq_ones_counter
//   Self-checking bench for seq_ones_counter with three instances:
//   inst 0: WIDTH=63 CHUNK=8, inst 1: WIDTH=7 CHUNK=3, inst 2: WIDTH=15 CHUNK=16.
//   Results and latencies are compared against a bit-counting reference model.
module tb_seq_ones_counter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic        start_s [3];
  logic        mode_s  [3];
  logic [62:0] din_s   [3];
  logic        ready_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [5:0]  count_v [3];

  seq_ones_counter_if #(.WIDTH(63)) if0 ();
  seq_ones_counter_if #(.WIDTH(7))  if1 ();
  seq_ones_counter_if #(.WIDTH(15)) if2 ();

  seq_ones_counter #(.WIDTH(63), .CHUNK(8))  u0 (.clk(clk), .rst(rst), .bus(if0));
  seq_ones_counter #(.WIDTH(7),  .CHUNK(3))  u1 (.clk(clk), .rst(rst), .bus(if1));
  seq_ones_counter #(.WIDTH(15), .CHUNK(16)) u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.start = start_s[0];
  assign if0.mode  = mode_s[0];
  assign if0.din   = din_s[0];
  assign if1.start = start_s[1];
  assign if1.mode  = mode_s[1];
  assign if1.din   = din_s[1][6:0];
  assign if2.start = start_s[2];
  assign if2.mode  = mode_s[2];
  assign if2.din   = din_s[2][14:0];

  assign ready_v[0] = if0.ready;
  assign ready_v[1] = if1.ready;
  assign ready_v[2] = if2.ready;
  assign busy_v[0]  = if0.busy;
  assign busy_v[1]  = if1.busy;
  assign busy_v[2]  = if2.busy;
  assign done_v[0]  = if0.done;
  assign done_v[1]  = if1.done;
  assign done_v[2]  = if2.done;
  assign count_v[0] = if0.count;
  assign count_v[1] = {3'b000, if1.count};
  assign count_v[2] = {2'b00, if2.count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid_of(input int inst);
    case (inst)
      0:       return 63;
      1:       return 7;
      default: return 15;
    endcase
  endfunction

  function automatic int chunk_of(input int inst);
    case (inst)
      0:       return 8;
      1:       return 3;
      default: return 16;
    endcase
  endfunction

  // Reference: number of ones (mode=0) or zeros (mode=1) in the low w bits.
  function automatic int ref_count(input logic [62:0] d, input int w, input logic m);
    int n;
    n = 0;
    for (int i = 0; i < w; i++) begin
      if (m == 1'b0 && d[i] == 1'b1) n++;
      if (m == 1'b1 && d[i] == 1'b0) n++;
    end
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on one instance; starts and ends with ready=1.
  task automatic run_word(input int inst, input logic [62:0] d, input logic m, input string name);
    int w, c, lat, expc, edges;
    w    = wid_of(inst);
    c    = chunk_of(inst);
    lat  = (w + c - 1) / c + 1;
    expc = ref_count(d, w, m);
    checks++;
    if (ready_v[inst] !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before got=%b want=1", name, ready_v[inst]);
    end
    din_s[inst]   = d;
    mode_s[inst]  = m;
    start_s[inst] = 1'b1;
    step();
    start_s[inst] = 1'b0;
    edges = 1;
    while (done_v[inst] !== 1'b1 && edges < 200) begin
      step();
      edges++;
    end
    checks++;
    if (edges != lat) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d", name, edges, lat);
    end
    checks++;
    if (count_v[inst] !== 6'(expc)) begin
      failures++;
      $display("FAIL %s count got=%0d want=%0d", name, count_v[inst], expc);
    end
    $display("TXN %s inst=%0d din=%h mode=%0d count=%0d exp=%0d edges=%0d",
             name, inst, d, m, count_v[inst], expc, edges);
    step();
    checks++;
    if (ready_v[inst] !== 1'b1 || done_v[inst] !== 1'b0 || count_v[inst] !== 6'(expc)) begin
      failures++;
      $display("FAIL %s after_done ready=%b done=%b count=%0d want ready=1 done=0 count=%0d",
               name, ready_v[inst], done_v[inst], count_v[inst], expc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ready_v[i] !== 1'b1 || busy_v[i] !== 1'b0 || done_v[i] !== 1'b0 || count_v[i] !== 6'd0) begin
        failures++;
        $display("FAIL reset inst=%0d ready=%b busy=%b done=%b count=%0d want 1/0/0/0",
                 i, ready_v[i], busy_v[i], done_v[i], count_v[i]);
      end
    end
  endtask

  task automatic test_zero_word();
    run_word(0, 63'd0, 1'b0, "zero_word");
  endtask

  task automatic test_modes();
    logic [62:0] ones;
    ones = '1;
    run_word(0, ones, 1'b0, "ones_mode0");
    run_word(0, ones, 1'b1, "ones_mode1");
    run_word(0, 63'd0, 1'b1, "zeros_mode1");
  endtask

  task automatic test_hold_start();
    logic [63:0] pat;
    logic [62:0] d;
    int edges, pulses;
    pat = 64'h5555_5555_5555_5555;
    d   = pat[62:0];
    din_s[0]   = d;
    mode_s[0]  = 1'b0;
    start_s[0] = 1'b1;
    step();
    edges  = 1;
    pulses = 0;
    // Changes while busy must be ignored.
    din_s[0]  = '1;
    mode_s[0] = 1'b1;
    while (ready_v[0] !== 1'b1 && edges < 50) begin
      if (done_v[0] === 1'b1) begin
        pulses++;
        checks++;
        if (count_v[0] !== 6'd32) begin
          failures++;
          $display("FAIL hold_start count got=%0d want=32", count_v[0]);
        end
        din_s[0]  = d;
        mode_s[0] = 1'b0;
      end
      step();
      edges++;
    end
    checks++;
    if (pulses != 1 || edges != 10) begin
      failures++;
      $display("FAIL hold_start pulses=%0d edges=%0d want pulses=1 edges=10", pulses, edges);
    end
    step();
    checks++;
    if (ready_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      failures++;
      $display("FAIL hold_start reaccept ready=%b busy=%b want ready=0 busy=1", ready_v[0], busy_v[0]);
    end
    start_s[0] = 1'b0;
    edges = 1;
    while (done_v[0] !== 1'b1 && edges < 50) begin
      step();
      edges++;
    end
    checks++;
    if (done_v[0] !== 1'b1 || count_v[0] !== 6'd32 || edges != 9) begin
      failures++;
      $display("FAIL hold_start second done=%b count=%0d edges=%0d want 1/32/9", done_v[0], count_v[0], edges);
    end
    $display("TXN hold_start second count=%0d edges=%0d", count_v[0], edges);
    step();
  endtask

  task automatic test_reset_mid_run();
    logic [62:0] ones;
    int spurious;
    ones = '1;
    din_s[0]   = {$urandom, $urandom};
    mode_s[0]  = 1'b0;
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || count_v[0] !== 6'd0 || done_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_run ready=%b busy=%b count=%0d done=%b want 1/0/0/0",
               ready_v[0], busy_v[0], count_v[0], done_v[0]);
    end
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_v[0] === 1'b1) spurious++;
      step();
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL reset_mid_run done_pulses got=%0d want=0", spurious);
    end
    // Reset and start together: reset wins, nothing is accepted.
    rst        = 1'b1;
    start_s[0] = 1'b1;
    step();
    rst        = 1'b0;
    start_s[0] = 1'b0;
    checks++;
    if (ready_v[0] !== 1'b1 || busy_v[0] !== 1'b0) begin
      failures++;
      $display("FAIL rst_with_start ready=%b busy=%b want ready=1 busy=0", ready_v[0], busy_v[0]);
    end
    run_word(0, ones, 1'b0, "after_reset_ones");
  endtask

  task automatic test_small_instance();
    run_word(1, 63'(7'b1110101), 1'b0, "w7_a");
    run_word(1, 63'(7'b0001001), 1'b0, "w7_b");
    run_word(1, 63'(7'b0010101), 1'b1, "w7_c");
  endtask

  task automatic test_wide_chunk();
    run_word(2, 63'(15'b111010101010000), 1'b0, "w15_a");
    run_word(2, 63'(15'b111010101010000), 1'b1, "w15_b");
  endtask

  task automatic test_random();
    logic [62:0] d;
    logic m;
    int inst, kind;
    for (int n = 0; n < 1000; n++) begin
      inst = int'($urandom_range(0, 2));
      kind = int'($urandom_range(0, 9));
      d    = {$urandom, $urandom};
      if (kind == 0) d = '0;
      if (kind == 1) d = '1;
      m = 1'($urandom_range(0, 1));
      run_word(inst, d, m, "random");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      mode_s[i]  = 1'b0;
      din_s[i]   = '0;
    end
    test_reset();
    test_zero_word();
    test_modes();
    test_hold_start();
    test_reset_mid_run();
    test_small_instance();
    test_wide_chunk();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
